// File: rtl/sddr_cmd_sched.sv
// Closed-page DDR3 command scheduler feeding the PHY ctl_* interface.
// One BL8 request at a time: ACT, then RD/WR with auto-precharge after
// T_RCD, then a fixed recovery before the next request. Periodic REFRESH
// takes priority over new requests. Idle (deselect) until init_done_i.
// Optional build macro: SDDR_SCHED_PERF_EN adds saturating RD/WR/REF
// issue counters on perf_*_cnt_o.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | waiting for a request or a due refresh
// S_WAIT_RCD | ACT issued, counting down to the RD/WR slot
// S_RECOVER  | RD/WR issued, waiting out data, write recovery, precharge
// S_WAIT_RFC | REF issued, waiting out T_RFC
module sddr_cmd_sched #(
    parameter int BANK_BITS        = 3,
    parameter int ROW_BITS         = 14,
    parameter int COL_BITS         = 10,
    parameter int DATA_BITS        = 16,
    parameter int T_RCD            = 5,
    parameter int T_RP             = 5,
    parameter int T_RAS            = 12,
    parameter int T_WR             = 6,
    parameter int T_RFC            = 44,
    parameter int T_REFI           = 2340,
    parameter int WR_DATA_DELAY    = 4,
    parameter int RD_CAPTURE_DELAY = 9
) (
    input  logic                   in_ddr_clock_i,
    input  logic                   in_ctl_reset_i,
    input  logic                   init_done_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [BANK_BITS-1:0]   req_ba_i,
    input  logic [ROW_BITS-1:0]    req_row_i,
    input  logic [COL_BITS-1:0]    req_col_i,
    input  logic [8*DATA_BITS-1:0] req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [8*DATA_BITS-1:0] rsp_rdata_o,
    output logic                   ctl_cs_n_o,
    output logic                   ctl_ras_n_o,
    output logic                   ctl_cas_n_o,
    output logic                   ctl_we_n_o,
    output logic [ROW_BITS-1:0]    ctl_addr_o,
    output logic [BANK_BITS-1:0]   ctl_ba_o,
    output logic                   ctl_odt_o,
    output logic                   ctl_data_write_o,
    output logic                   ctl_out_dqs_o,
    output logic [2*DATA_BITS-1:0] ctl_dq_o,
    input  logic [8*DATA_BITS-1:0] ctl_dq_i,
    output logic                   refresh_overrun_o
`ifdef SDDR_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_rd_cnt_o,
    output logic [31:0]            perf_wr_cnt_o,
    output logic [31:0]            perf_ref_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_RCD = 2'd1;
    localparam logic [1:0] S_RECOVER  = 2'd2;
    localparam logic [1:0] S_WAIT_RFC = 2'd3;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    // Recovery is measured from the RD/WR cycle; auto-precharge cannot start
    // before T_RAS from ACT, nor before write recovery has elapsed.
    localparam int RD_REC_I  = ((T_RAS - T_RCD) > 4 ? (T_RAS - T_RCD) : 4) + T_RP;
    localparam int WR_REC_I  = WR_DATA_DELAY + 4 + T_WR + T_RP;
    localparam int AGE_MAX_I = (WR_DATA_DELAY + 4 > RD_CAPTURE_DELAY + 1) ?
                               WR_DATA_DELAY + 4 : RD_CAPTURE_DELAY + 1;

    localparam logic [15:0] RCD_LD    = 16'(T_RCD - 1);
    localparam logic [15:0] RFC_LD    = 16'(T_RFC - 1);
    localparam logic [15:0] RD_REC_LD = 16'(RD_REC_I - 1);
    localparam logic [15:0] WR_REC_LD = 16'(WR_REC_I - 1);
    localparam logic [15:0] REFI_LD   = 16'(T_REFI - 1);

    // Age = clocks since the RD/WR command; drives the data-side windows.
    localparam logic [7:0] AGE_MAX   = 8'(AGE_MAX_I);
    localparam logic [7:0] A_DQS_ON  = 8'(WR_DATA_DELAY - 1);
    localparam logic [7:0] A_DQS_OFF = 8'(WR_DATA_DELAY + 4);
    localparam logic [7:0] A_DW_ON   = 8'(WR_DATA_DELAY);
    localparam logic [7:0] A_DW_OFF  = 8'(WR_DATA_DELAY + 3);
    localparam logic [7:0] A_CAP     = 8'(RD_CAPTURE_DELAY);
    localparam logic [7:0] A_RSP     = 8'(RD_CAPTURE_DELAY + 1);

    logic [1:0]             state, state_nx;
    logic [15:0]            wait_cnt, wait_nx;
    logic [15:0]            refi_cnt, refi_nx;
    logic                   refi_expire, refresh_pending, pend_nx, clear_pend;
    logic                   accept, ready_nx;
    logic                   issue_act, issue_rw, issue_ref;
    logic [3:0]             cmd_q;
    logic                   cur_write;
    logic [COL_BITS-1:3]    cur_col;
    logic [8*DATA_BITS-1:0] cur_wdata;
    logic [ROW_BITS-1:0]    col_addr;
    logic [7:0]             age;
    logic                   age_wr;
    logic [2*DATA_BITS-1:0] wr_pair;
    logic [8*DATA_BITS-1:0] rd_capture;
    logic                   col_lsb_unused;

    // Burst-aligned column: low three bits are always zero for BL8.
    assign col_lsb_unused = ^req_col_i[2:0];
    assign {ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} = cmd_q;

    // Column address with A10 set for auto-precharge.
    always_comb begin
        col_addr = '0;
        col_addr[COL_BITS-1:3] = cur_col;
        col_addr[10] = 1'b1;
    end

    // Next-state, refresh timer and ready look-ahead.
    always_comb begin
        refi_expire = init_done_i && (refi_cnt == '0);
        refi_nx     = refi_cnt;
        if (init_done_i) refi_nx = refi_expire ? REFI_LD : refi_cnt - 16'd1;
        accept     = req_valid_i && req_ready_o;
        state_nx   = state;
        wait_nx    = wait_cnt;
        issue_act  = 1'b0;
        issue_rw   = 1'b0;
        issue_ref  = 1'b0;
        clear_pend = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done_i && (refresh_pending || refi_expire)) begin
                    issue_ref = 1'b1;
                    state_nx  = S_WAIT_RFC;
                    wait_nx   = RFC_LD;
                end else if (accept) begin
                    issue_act = 1'b1;
                    state_nx  = S_WAIT_RCD;
                    wait_nx   = RCD_LD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_cnt == '0) begin
                    issue_rw = 1'b1;
                    state_nx = S_RECOVER;
                    wait_nx  = cur_write ? WR_REC_LD : RD_REC_LD;
                end else begin
                    wait_nx = wait_cnt - 16'd1;
                end
            end
            S_RECOVER: begin
                if (wait_cnt == '0) state_nx = S_IDLE;
                else wait_nx = wait_cnt - 16'd1;
            end
            S_WAIT_RFC: begin
                if (wait_cnt == '0) begin
                    state_nx   = S_IDLE;
                    clear_pend = 1'b1;
                end else begin
                    wait_nx = wait_cnt - 16'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        pend_nx = refi_expire ? 1'b1 : (clear_pend ? 1'b0 : refresh_pending);
        // Drop ready one clock ahead of a refresh expiry so refresh always
        // wins over a request arriving in the same cycle.
        ready_nx = (state_nx == S_IDLE) && init_done_i && !pend_nx && (refi_nx != '0);
    end

    // Control FSM, refresh tracking and command/address outputs.
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ctl_reset_i) begin
            state             <= S_IDLE;
            wait_cnt          <= '0;
            refi_cnt          <= REFI_LD;
            refresh_pending   <= 1'b0;
            refresh_overrun_o <= 1'b0;
            req_ready_o       <= 1'b0;
            cmd_q             <= CMD_DESEL;
            ctl_addr_o        <= '0;
            ctl_ba_o          <= '0;
            cur_write         <= 1'b0;
            cur_col           <= '0;
            cur_wdata         <= '0;
        end else begin
            state           <= state_nx;
            wait_cnt        <= wait_nx;
            refi_cnt        <= refi_nx;
            refresh_pending <= pend_nx;
            req_ready_o     <= ready_nx;
            if (refi_expire && refresh_pending) refresh_overrun_o <= 1'b1;
            cmd_q <= (state == S_IDLE && !init_done_i) ? CMD_DESEL : CMD_NOP;
            if (issue_act) begin
                cmd_q      <= CMD_ACT;
                ctl_addr_o <= req_row_i;
                ctl_ba_o   <= req_ba_i;
                cur_write  <= req_write_i;
                cur_col    <= req_col_i[COL_BITS-1:3];
                cur_wdata  <= req_wdata_i;
            end
            if (issue_rw) begin
                cmd_q      <= cur_write ? CMD_WR : CMD_RD;
                ctl_addr_o <= col_addr;
            end
            if (issue_ref) cmd_q <= CMD_REF;
        end
    end

    // Beat pair for the current write data clock, rising beat in the low half.
    always_comb begin
        wr_pair = '0;
        case (age)
            A_DW_ON:         wr_pair = cur_wdata[0*DATA_BITS +: 2*DATA_BITS];
            A_DW_ON + 8'd1:  wr_pair = cur_wdata[2*DATA_BITS +: 2*DATA_BITS];
            A_DW_ON + 8'd2:  wr_pair = cur_wdata[4*DATA_BITS +: 2*DATA_BITS];
            A_DW_ON + 8'd3:  wr_pair = cur_wdata[6*DATA_BITS +: 2*DATA_BITS];
            default:         wr_pair = '0;
        endcase
    end

    // Write data/strobe windows and read capture, timed from the RD/WR cycle.
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ctl_reset_i) begin
            age              <= '0;
            age_wr           <= 1'b0;
            ctl_data_write_o <= 1'b0;
            ctl_out_dqs_o    <= 1'b0;
            ctl_odt_o        <= 1'b0;
            ctl_dq_o         <= '0;
            rd_capture       <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_rdata_o      <= '0;
        end else begin
            ctl_data_write_o <= 1'b0;
            ctl_out_dqs_o    <= 1'b0;
            ctl_odt_o        <= 1'b0;
            ctl_dq_o         <= '0;
            rsp_valid_o      <= 1'b0;
            if (issue_rw) begin
                age    <= 8'd1;
                age_wr <= cur_write;
            end else if (age != '0) begin
                age <= (age == AGE_MAX) ? 8'd0 : age + 8'd1;
            end
            if (age != '0 && age_wr) begin
                if (age >= A_DQS_ON && age <= A_DQS_OFF) begin
                    ctl_out_dqs_o <= 1'b1;
                    ctl_odt_o     <= 1'b1;
                end
                if (age >= A_DW_ON && age <= A_DW_OFF) begin
                    ctl_data_write_o <= 1'b1;
                    ctl_dq_o         <= wr_pair;
                end
            end
            if (age != '0 && !age_wr) begin
                if (age == A_CAP) rd_capture <= ctl_dq_i;
                if (age == A_RSP) begin
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= rd_capture;
                end
            end
        end
    end

`ifdef SDDR_SCHED_PERF_EN
    // Saturating command issue counters.
    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ctl_reset_i) begin
            perf_rd_cnt_o  <= '0;
            perf_wr_cnt_o  <= '0;
            perf_ref_cnt_o <= '0;
        end else begin
            if (issue_rw && !cur_write && perf_rd_cnt_o != '1) perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
            if (issue_rw && cur_write && perf_wr_cnt_o != '1) perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
            if (issue_ref && perf_ref_cnt_o != '1) perf_ref_cnt_o <= perf_ref_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sddr_cmd_sched.sv
// Directed bench for sddr_cmd_sched: request vector table plus refresh,
// init, overrun and reset corner sequences. A second instance with a short
// refresh interval exercises the overrun flag.
module tb_sddr_cmd_sched;

    localparam logic [3:0] C_DESEL = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_RD    = 4'b0101;
    localparam logic [3:0] C_WR    = 4'b0100;
    localparam logic [3:0] C_REF   = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst, init_done, req_valid, req_write;
    logic [2:0]   req_ba;
    logic [13:0]  req_row;
    logic [9:0]   req_col;
    logic [127:0] req_wdata, dq_in;
    logic         req_ready, rsp_valid, cs_n, ras_n, cas_n, we_n, odt, dwr, dqs, ovr;
    logic [127:0] rsp_rdata;
    logic [13:0]  addr;
    logic [2:0]   ba;
    logic [31:0]  dq_out;
    logic [3:0]   cmd;
    assign cmd = {cs_n, ras_n, cas_n, we_n};

    logic         rst2, init2, z_bit;
    logic [2:0]   z_ba;
    logic [13:0]  z_row;
    logic [9:0]   z_col;
    logic [127:0] z_wide;
    logic         ready2, rsp_valid2, cs2, ras2, cas2, we2, odt2, dwr2, dqs2, ovr2;
    logic [127:0] rdata2;
    logic [13:0]  addr2;
    logic [2:0]   ba2;
    logic [31:0]  dq2;
`ifdef SDDR_SCHED_PERF_EN
    logic [31:0]  p_rd, p_wr, p_ref, p_rd2, p_wr2, p_ref2;
`endif

    sddr_cmd_sched u_dut (
        .in_ddr_clock_i(clk), .in_ctl_reset_i(rst), .init_done_i(init_done),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_ba_i(req_ba), .req_row_i(req_row), .req_col_i(req_col), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .ctl_cs_n_o(cs_n), .ctl_ras_n_o(ras_n), .ctl_cas_n_o(cas_n), .ctl_we_n_o(we_n),
        .ctl_addr_o(addr), .ctl_ba_o(ba), .ctl_odt_o(odt), .ctl_data_write_o(dwr),
        .ctl_out_dqs_o(dqs), .ctl_dq_o(dq_out), .ctl_dq_i(dq_in), .refresh_overrun_o(ovr)
`ifdef SDDR_SCHED_PERF_EN
        , .perf_rd_cnt_o(p_rd), .perf_wr_cnt_o(p_wr), .perf_ref_cnt_o(p_ref)
`endif
    );

    sddr_cmd_sched #(.T_REFI(40)) u_dut_ovr (
        .in_ddr_clock_i(clk), .in_ctl_reset_i(rst2), .init_done_i(init2),
        .req_valid_i(z_bit), .req_ready_o(ready2), .req_write_i(z_bit),
        .req_ba_i(z_ba), .req_row_i(z_row), .req_col_i(z_col), .req_wdata_i(z_wide),
        .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rdata2),
        .ctl_cs_n_o(cs2), .ctl_ras_n_o(ras2), .ctl_cas_n_o(cas2), .ctl_we_n_o(we2),
        .ctl_addr_o(addr2), .ctl_ba_o(ba2), .ctl_odt_o(odt2), .ctl_data_write_o(dwr2),
        .ctl_out_dqs_o(dqs2), .ctl_dq_o(dq2), .ctl_dq_i(z_wide), .refresh_overrun_o(ovr2)
`ifdef SDDR_SCHED_PERF_EN
        , .perf_rd_cnt_o(p_rd2), .perf_wr_cnt_o(p_wr2), .perf_ref_cnt_o(p_ref2)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic         wr;
        logic [2:0]   ba;
        logic [13:0]  row;
        logic [9:0]   col;
        logic [127:0] wdata;
        logic [127:0] rbeats;
        logic [13:0]  exp_col_addr;
        logic [3:0]   exp_cmd;
        int           exp_gap;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(name, 128'(n < 300), 128'd1);
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1;
        req_write = v.wr;
        req_ba    = v.ba;
        req_row   = v.row;
        req_col   = v.col;
        req_wdata = v.wdata;
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready("vec_ready_wait");
        drive_req(v);
        tick();
        req_valid = 1'b0;
        check("act_cmd", cmd, C_ACT);
        check("act_addr", addr, v.row);
        check("act_ba", ba, v.ba);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rcd_gap_nop", cmd, C_NOP);
        end
        tick();
        check("rw_cmd", cmd, v.exp_cmd);
        check("rw_addr", addr, v.exp_col_addr);
        check("rw_ba", ba, v.ba);
        for (int k = 1; k <= v.exp_gap; k++) begin
            tick();
            if (v.wr) begin
                check("data_write", dwr, 128'(k >= 4 && k <= 7));
                check("out_dqs", dqs, 128'(k >= 3 && k <= 8));
                check("odt", odt, 128'(k >= 3 && k <= 8));
                if (k >= 4 && k <= 7) check("dq_pair", dq_out, v.wdata[(k-4)*32 +: 32]);
            end else begin
                if (k == 8) dq_in = v.rbeats;
                if (k == 9) dq_in = '0;
                check("rsp_valid", rsp_valid, 128'(k == 10));
                if (k == 10) check("rsp_rdata", rsp_rdata, v.rbeats);
            end
            check("ready_gap", req_ready, 128'(k == v.exp_gap));
        end
    endtask

    initial begin
        int c0, ref_cyc, act_cyc, lowcnt, bad, other;
        logic pre_ready, early_ready;
        logic [3:0] first_cmd;

        vecs[0] = '{1'b1, 3'd2, 14'h1234, 10'h3FF, 128'hb7b7_b6b6_b5b5_b4b4_b3b3_b2b2_b1b1_b0b0,
                    128'h0, 14'h7F8, C_WR, 19};
        vecs[1] = '{1'b0, 3'd0, 14'h0005, 10'h010, 128'h0,
                    128'h0007_0006_0005_0004_0003_0002_0001_0000, 14'h410, C_RD, 12};
        vecs[2] = '{1'b1, 3'd7, 14'h3FFF, 10'h000, 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe,
                    128'h0, 14'h400, C_WR, 19};
        vecs[3] = '{1'b0, 3'd5, 14'h0000, 10'h207, 128'h0,
                    128'hffff_0000_aaaa_5555_1234_5678_9abc_def0, 14'h600, C_RD, 12};

        rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_ba = '0; req_row = '0; req_col = '0; req_wdata = '0; dq_in = '0;
        rst2 = 1'b1; init2 = 1'b0; z_bit = 1'b0; z_ba = '0; z_row = '0; z_col = '0; z_wide = '0;
        repeat (3) tick();

        check("reset_cmd", cmd, C_DESEL);
        check("reset_ready", req_ready, 0);
        check("reset_addr", addr, 0);
        check("reset_ba", ba, 0);
        check("reset_dwr_dqs_odt", {dwr, dqs, odt}, 0);
        check("reset_dq", dq_out, 0);
        check("reset_rsp", {rsp_valid, rsp_rdata}, 0);
        check("reset_overrun", ovr, 0);

        // init_done held low: nothing issued, timer frozen.
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (cmd !== C_DESEL || req_ready !== 1'b0 || ovr !== 1'b0) bad++;
        end
        check("init_low_quiet", bad, 0);

        // First refresh exactly T_REFI clocks after init completes.
        init_done = 1'b1;
        c0 = cyc;
        ref_cyc = -1;
        pre_ready = 1'bx;
        early_ready = 1'bx;
        first_cmd = C_NOP;
        for (int i = 0; i < 2400 && ref_cyc < 0; i++) begin
            tick();
            if (cyc == c0 + 10) early_ready = req_ready;
            if (cyc == c0 + 2339) pre_ready = req_ready;
            if (cmd !== C_NOP) begin
                ref_cyc = cyc;
                first_cmd = cmd;
            end
        end
        check("first_cmd_is_ref", first_cmd, C_REF);
        check("ref_after_refi", ref_cyc - c0, 2340);
        check("ready_after_init", early_ready, 1);
        check("ready_drops_before_ref", pre_ready, 0);
        lowcnt = 0;
        while (req_ready === 1'b0 && lowcnt < 100) begin
            lowcnt++;
            tick();
        end
        check("ready_low_trfc", lowcnt, 44);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Request waiting as the refresh timer expires: REF goes first.
        while (cyc < ref_cyc + 2339) tick();
        check("ready_low_pre_expiry", req_ready, 0);
        drive_req(vecs[1]);
        tick();
        check("ref_beats_request", cmd, C_REF);
        c0 = cyc;
        act_cyc = -1;
        other = 0;
        for (int i = 0; i < 100 && act_cyc < 0; i++) begin
            tick();
            if (cmd === C_ACT) act_cyc = cyc;
            else if (cmd !== C_NOP) other++;
        end
        req_valid = 1'b0;
        check("act_after_rfc", act_cyc - c0, 45);
        check("no_cmd_during_rfc", other, 0);
        check("act_row_after_ref", addr, vecs[1].row);
        wait_ready("post_ref_ready");
        check("no_overrun_normal", ovr, 0);

        // Reset in the middle of a write data window.
        wait_ready("rst_wr_ready");
        drive_req(vecs[0]);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("rst_wr_cmd_seen", cmd, C_WR);
        repeat (5) tick();
        check("rst_window_open", dwr, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_dwr", dwr, 0);
        check("rst_mid_dqs", dqs, 0);
        check("rst_mid_odt", odt, 0);
        check("rst_mid_cmd", cmd, C_DESEL);
        check("rst_mid_ready", req_ready, 0);
        rst = 1'b0;

        // Reset with a read in flight: its response must never appear.
        wait_ready("rst_rd_ready");
        drive_req(vecs[1]);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("rst_rd_cmd_seen", cmd, C_RD);
        repeat (3) tick();
        rst = 1'b1;
        dq_in = vecs[3].rbeats;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        dq_in = '0;
        check("rst_drops_read", bad, 0);

        // Short refresh interval: second expiry inside WAIT_RFC is an overrun.
        rst2 = 1'b0;
        tick();
        init2 = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 30) tick();
        check("ovr_clear_early", ovr2, 0);
        while (cyc < c0 + 70) tick();
        check("ovr_clear_in_rfc", ovr2, 0);
        while (cyc < c0 + 90) tick();
        check("ovr_set", ovr2, 1);
        while (cyc < c0 + 400) tick();
        check("ovr_sticky", ovr2, 1);
        rst2 = 1'b1;
        tick();
        check("ovr_cleared_by_reset", ovr2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
